// File: rtl/cpu_branch_unit.sv
// Next-PC / branch target unit with a LIFO return-address stack and sticky error flags.
// Optional PC-relative mode (010) is built only when CPU_BRANCH_PCREL_EN is defined.
module cpu_branch_unit #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [WIDTH-1:0]                 PC,
  input  logic                             JMP_EN,
  input  logic [2:0]                       JMP_MODE,
  input  logic [WIDTH-1:0]                 OFFSET,
  input  logic                             BASE_REG_LD,
  input  logic [WIDTH-1:0]                 BASE_REG_DATA,
  input  logic                             ERR_CLR,
  output logic [WIDTH-1:0]                 ADDRESS_OUT,
  output logic                             JMP_TAKEN,
  output logic [$clog2(STACK_DEPTH+1)-1:0] STACK_CNT,
  output logic                             STACK_OVF,
  output logic                             STACK_UNF,
  output logic                             MODE_ERR
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic             stack_full;
  logic             stack_empty;
  logic             do_push;
  logic             do_pop;
  logic             ovf_ev;
  logic             unf_ev;
  logic             mode_ev;

  assign pc_inc      = PC + WIDTH'(1);
  assign stack_full  = (STACK_CNT == CW'(STACK_DEPTH));
  assign stack_empty = (STACK_CNT == '0);
  assign push_idx    = AW'(STACK_CNT);
  assign top_idx     = AW'(STACK_CNT - CW'(1));

  always_comb begin
    ADDRESS_OUT = pc_inc;
    JMP_TAKEN   = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    ovf_ev      = 1'b0;
    unf_ev      = 1'b0;
    mode_ev     = 1'b0;
    if (JMP_EN) begin
      case (JMP_MODE)
        3'b000: begin  // absolute
          ADDRESS_OUT = OFFSET;
          JMP_TAKEN   = 1'b1;
        end
        3'b001: begin  // base-relative, unsigned offset
          ADDRESS_OUT = base + OFFSET;
          JMP_TAKEN   = 1'b1;
        end
`ifdef CPU_BRANCH_PCREL_EN
        3'b010: begin  // same-width add is the sign-extended add modulo 2^WIDTH
          ADDRESS_OUT = PC + OFFSET;
          JMP_TAKEN   = 1'b1;
        end
`endif
        3'b011: begin  // CALL still jumps when the stack is full; only the push is dropped
          ADDRESS_OUT = OFFSET;
          JMP_TAKEN   = 1'b1;
          if (stack_full) ovf_ev  = 1'b1;
          else            do_push = 1'b1;
        end
        3'b100: begin
          if (stack_empty) begin
            unf_ev = 1'b1;
          end else begin
            ADDRESS_OUT = stack[top_idx];
            JMP_TAKEN   = 1'b1;
            do_pop      = 1'b1;
          end
        end
        default: mode_ev = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      base      <= '0;
      STACK_CNT <= '0;
      STACK_OVF <= 1'b0;
      STACK_UNF <= 1'b0;
      MODE_ERR  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      if (BASE_REG_LD) base <= BASE_REG_DATA;
      if (do_push) begin
        stack[push_idx] <= pc_inc;
        STACK_CNT       <= STACK_CNT + CW'(1);
      end else if (do_pop) begin
        STACK_CNT <= STACK_CNT - CW'(1);
      end
      // A same-cycle error event overrides the clear
      STACK_OVF <= (STACK_OVF & ~ERR_CLR) | ovf_ev;
      STACK_UNF <= (STACK_UNF & ~ERR_CLR) | unf_ev;
      MODE_ERR  <= (MODE_ERR  & ~ERR_CLR) | mode_ev;
    end
  end

endmodule

// File: tb/tb_cpu_branch_unit.sv
// Bench for cpu_branch_unit: queue-based reference model checked every cycle, plus literal checks.
module tb_cpu_branch_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] PC = '0;
  logic             JMP_EN = 1'b0;
  logic [2:0]       JMP_MODE = '0;
  logic [WIDTH-1:0] OFFSET = '0;
  logic             BASE_REG_LD = 1'b0;
  logic [WIDTH-1:0] BASE_REG_DATA = '0;
  logic             ERR_CLR = 1'b0;
  logic [WIDTH-1:0] ADDRESS_OUT;
  logic             JMP_TAKEN;
  logic [2:0]       STACK_CNT;
  logic             STACK_OVF;
  logic             STACK_UNF;
  logic             MODE_ERR;

  int tests  = 0;
  int errors = 0;

  cpu_branch_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .JMP_EN(JMP_EN), .JMP_MODE(JMP_MODE),
    .OFFSET(OFFSET), .BASE_REG_LD(BASE_REG_LD), .BASE_REG_DATA(BASE_REG_DATA),
    .ERR_CLR(ERR_CLR), .ADDRESS_OUT(ADDRESS_OUT), .JMP_TAKEN(JMP_TAKEN),
    .STACK_CNT(STACK_CNT), .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF), .MODE_ERR(MODE_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  int m_stk[$];
  int m_base = 0;
  bit m_ovf = 0, m_unf = 0, m_merr = 0;
  int e_addr;
  bit e_taken, e_push, e_pop, e_ovf, e_unf, e_merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function void model_eval();
    int pc, off;
    pc = int'(PC);
    off = int'(OFFSET);
    e_addr = (pc + 1) % 256;
    e_taken = 0; e_push = 0; e_pop = 0; e_ovf = 0; e_unf = 0; e_merr = 0;
    if (JMP_EN) begin
      case (int'(JMP_MODE))
        0: begin e_addr = off; e_taken = 1; end
        1: begin e_addr = (m_base + off) % 256; e_taken = 1; end
`ifdef CPU_BRANCH_PCREL_EN
        2: begin e_addr = (pc + (off >= 128 ? off - 256 : off) + 256) % 256; e_taken = 1; end
`endif
        3: begin
          e_addr = off; e_taken = 1;
          if (m_stk.size() == DEPTH) e_ovf = 1; else e_push = 1;
        end
        4: begin
          if (m_stk.size() == 0) e_unf = 1;
          else begin e_addr = m_stk[$]; e_taken = 1; e_pop = 1; end
        end
        default: e_merr = 1;
      endcase
    end
  endfunction

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      model_eval();
      if (e_push) m_stk.push_back((int'(PC) + 1) % 256);
      if (e_pop) void'(m_stk.pop_back());
      m_ovf  = (m_ovf  && !ERR_CLR) || e_ovf;
      m_unf  = (m_unf  && !ERR_CLR) || e_unf;
      m_merr = (m_merr && !ERR_CLR) || e_merr;
      if (BASE_REG_LD) m_base = int'(BASE_REG_DATA);
    end
  end

  always @(negedge RST) begin
    m_stk.delete();
    m_base = 0; m_ovf = 0; m_unf = 0; m_merr = 0;
  end

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      model_eval();
      chk("model_addr",  32'(ADDRESS_OUT), 32'(e_addr));
      chk("model_taken", 32'(JMP_TAKEN),   32'(e_taken));
      chk("model_cnt",   32'(STACK_CNT),   32'(m_stk.size()));
      chk("model_ovf",   32'(STACK_OVF),   32'(m_ovf));
      chk("model_unf",   32'(STACK_UNF),   32'(m_unf));
      chk("model_merr",  32'(MODE_ERR),    32'(m_merr));
    end
  end

  // Drive one cycle just after the rising edge, return just after the falling edge
  task automatic cyc(input logic en, input logic [2:0] mode, input logic [7:0] pc,
                     input logic [7:0] off, input logic ld, input logic [7:0] bd, input logic clr);
    @(posedge CLK); #1;
    JMP_EN = en; JMP_MODE = mode; PC = pc; OFFSET = off;
    BASE_REG_LD = ld; BASE_REG_DATA = bd; ERR_CLR = clr;
    @(negedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_addr", 32'(ADDRESS_OUT), 32'h01);
    chk("rst_cnt",  32'(STACK_CNT),   32'd0);
    chk("rst_flags", {29'd0, STACK_OVF, STACK_UNF, MODE_ERR}, 32'd0);
    @(posedge CLK); #1 RST = 1'b1;

    cyc(1, 3'b000, 8'h10, 8'h40, 0, 8'h00, 0);
    chk("abs_addr", 32'(ADDRESS_OUT), 32'h40);
    chk("abs_taken", 32'(JMP_TAKEN), 32'd1);

    cyc(1, 3'b001, 8'h00, 8'h20, 1, 8'hF0, 0);
    chk("base_old", 32'(ADDRESS_OUT), 32'h20);
    cyc(1, 3'b001, 8'h00, 8'h20, 0, 8'h00, 0);
    chk("base_wrap", 32'(ADDRESS_OUT), 32'h10);

    cyc(1, 3'b010, 8'h05, 8'hFE, 0, 8'h00, 0);
`ifdef CPU_BRANCH_PCREL_EN
    chk("pcrel_addr", 32'(ADDRESS_OUT), 32'h03);
    chk("pcrel_taken", 32'(JMP_TAKEN), 32'd1);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("pcrel_merr", 32'(MODE_ERR), 32'd0);
`else
    chk("pcrel_addr", 32'(ADDRESS_OUT), 32'h06);
    chk("pcrel_taken", 32'(JMP_TAKEN), 32'd0);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("pcrel_merr", 32'(MODE_ERR), 32'd1);
`endif

    cyc(1, 3'b111, 8'h33, 8'h99, 0, 8'h00, 0);
    chk("inv_addr", 32'(ADDRESS_OUT), 32'h34);
    chk("inv_merr_cleared", 32'(MODE_ERR), 32'd0);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("inv_merr_set", 32'(MODE_ERR), 32'd1);

    for (int i = 1; i <= 4; i++) begin
      cyc(1, 3'b011, 8'(i), 8'(8'h80 + i), 0, 8'h00, 0);
      chk("call_addr", 32'(ADDRESS_OUT), 32'(8'h80 + i));
      chk("call_cnt", 32'(STACK_CNT), 32'(i - 1));
    end
    cyc(1, 3'b011, 8'h05, 8'h90, 0, 8'h00, 0);
    chk("ovf_call_addr", 32'(ADDRESS_OUT), 32'h90);
    chk("ovf_call_taken", 32'(JMP_TAKEN), 32'd1);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 0);
    chk("ovf_flag", 32'(STACK_OVF), 32'd1);
    chk("ovf_cnt", 32'(STACK_CNT), 32'd4);

    for (int k = 1; k <= 4; k++) begin
      cyc(1, 3'b100, 8'h60, 8'h00, 0, 8'h00, 0);
      chk("ret_addr", 32'(ADDRESS_OUT), 32'(6 - k));
    end
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("ret_cnt", 32'(STACK_CNT), 32'd0);

    cyc(1, 3'b011, 8'h20, 8'h70, 0, 8'h00, 0);
    cyc(1, 3'b100, 8'h70, 8'h00, 0, 8'h00, 0);
    chk("b2b_ret_addr", 32'(ADDRESS_OUT), 32'h21);
    chk("b2b_ovf_cleared", 32'(STACK_OVF), 32'd0);

    cyc(1, 3'b100, 8'hFF, 8'h00, 0, 8'h00, 0);
    chk("unf_addr", 32'(ADDRESS_OUT), 32'h00);
    chk("unf_taken", 32'(JMP_TAKEN), 32'd0);
    cyc(1, 3'b100, 8'hFF, 8'h00, 0, 8'h00, 1);
    chk("unf_flag", 32'(STACK_UNF), 32'd1);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 1);
    chk("unf_clr_loses", 32'(STACK_UNF), 32'd1);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 0);
    chk("unf_cleared", 32'(STACK_UNF), 32'd0);

    cyc(1, 3'b011, 8'h01, 8'h40, 0, 8'h00, 0);
    cyc(1, 3'b011, 8'h02, 8'h50, 0, 8'h00, 0);
    chk("pre_rst_cnt", 32'(STACK_CNT), 32'd1);
    RST = 1'b0;
    JMP_EN = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(STACK_CNT), 32'd0);
    @(posedge CLK); #1 RST = 1'b1;
    cyc(1, 3'b100, 8'h30, 8'h00, 0, 8'h00, 0);
    chk("post_rst_ret_addr", 32'(ADDRESS_OUT), 32'h31);
    cyc(0, 3'b000, 8'h00, 8'h00, 0, 8'h00, 0);
    chk("post_rst_unf", 32'(STACK_UNF), 32'd1);
    chk("post_rst_cnt", 32'(STACK_CNT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
